// File: rtl/cr_huf_comp_sa_axi4s_ib.sv
// rtl/cr_huf_comp_sa_axi4s_ib.sv - AXI4-stream slave input buffer (FWFT FIFO) feeding the TLV parser
module cr_huf_comp_sa_axi4s_ib #(
    parameter int DEPTH      = 16,
    parameter int AEMPTY_VAL = 1,
    parameter int DW         = 64,
    parameter int UW         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     axi4s_ib_tvalid,
    output logic                     axi4s_ib_tready,
    input  logic [DW-1:0]            axi4s_ib_tdata,
    input  logic [DW/8-1:0]          axi4s_ib_tstrb,
    input  logic [UW-1:0]            axi4s_ib_tuser,
    input  logic                     axi4s_ib_tid,
    input  logic                     axi4s_ib_tlast,
    output logic                     ib_empty,
    output logic                     ib_aempty,
    input  logic                     ib_rd,
    output logic [DW+DW/8+UW+1:0]    ib_data,
    output logic [15:0]              frame_cnt,
    output logic                     underflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + DW/8 + UW + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   occ, occ_next;
    logic          tready_q, tready_d;
    logic          empty_q, empty_d;
    logic          aempty_q, aempty_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          underflow_q, underflow_d;
    logic          push, pop;

    assign push = axi4s_ib_tvalid & tready_q;
    assign pop  = ib_rd & ~empty_q;
    assign occ  = wptr_q - rptr_q;

    // Status flags are registered from the post-update occupancy so they track occ exactly
    always_comb begin
        wptr_d      = wptr_q + (AW+1)'(push);
        rptr_d      = rptr_q + (AW+1)'(pop);
        occ_next    = occ + (AW+1)'(push) - (AW+1)'(pop);
        tready_d    = occ_next < (AW+1)'(DEPTH);
        empty_d     = occ_next == '0;
        aempty_d    = occ_next <= (AW+1)'(AEMPTY_VAL);
        frame_cnt_d = frame_cnt_q;
        if (pop && ib_data[EW-1]) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        underflow_d = underflow_q | (ib_rd & empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            tready_q    <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            frame_cnt_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            tready_q    <= tready_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            frame_cnt_q <= frame_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {axi4s_ib_tlast, axi4s_ib_tid, axi4s_ib_tuser,
                                      axi4s_ib_tstrb, axi4s_ib_tdata};
        end
    end

    assign ib_data         = mem_q[rptr_q[AW-1:0]];
    assign axi4s_ib_tready = tready_q;
    assign ib_empty        = empty_q;
    assign ib_aempty       = aempty_q;
    assign frame_cnt       = frame_cnt_q;
    assign underflow_err   = underflow_q;
endmodule

// File: tb/tb_cr_huf_comp_sa_axi4s_ib.sv
// tb/tb_cr_huf_comp_sa_axi4s_ib.sv - self-checking bench for cr_huf_comp_sa_axi4s_ib
module tb_cr_huf_comp_sa_axi4s_ib;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int EW = DW + DW/8 + UW + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tvalid = 1'b0;
    logic              tready;
    logic [DW-1:0]     tdata = '0;
    logic [DW/8-1:0]   tstrb = '0;
    logic [UW-1:0]     tuser = '0;
    logic              tid = 1'b0;
    logic              tlast = 1'b0;
    logic              ib_empty, ib_aempty;
    logic              ib_rd = 1'b0;
    logic [EW-1:0]     ib_data;
    logic [15:0]       frame_cnt;
    logic              underflow_err;

    cr_huf_comp_sa_axi4s_ib #(.DEPTH(16), .AEMPTY_VAL(1), .DW(DW), .UW(UW)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi4s_ib_tvalid(tvalid), .axi4s_ib_tready(tready),
        .axi4s_ib_tdata(tdata), .axi4s_ib_tstrb(tstrb), .axi4s_ib_tuser(tuser),
        .axi4s_ib_tid(tid), .axi4s_ib_tlast(tlast),
        .ib_empty(ib_empty), .ib_aempty(ib_aempty), .ib_rd(ib_rd),
        .ib_data(ib_data), .frame_cnt(frame_cnt), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]   data;
        logic [7:0]    strb;
        logic [7:0]    user;
        logic          id;
        logic          last;
        logic [EW-1:0] exp_head;
        int            exp_finc;
    } vec_t;

    vec_t          vecs [4];
    logic [EW-1:0] sb [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            accepted = 0;
    int            stalls = 0;
    logic          rdy_model = 1'b0;
    logic          uf_model = 1'b0;
    logic [15:0]   frames_model = '0;
    logic [15:0]   fbase;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_beat(input logic [63:0] d, input logic last);
        return {last, 1'b0, 8'h5A, 8'hFF, d};
    endfunction

    // One clock: check current outputs against the model, drive inputs, advance to edge+1
    task automatic step(input logic v, input logic [EW-1:0] beat, input logic rd);
        logic [EW-1:0] exp_head;
        chk("tready", 128'(tready), 128'(rdy_model));
        chk("ib_empty", 128'(ib_empty), 128'(sb.size() == 0));
        chk("ib_aempty", 128'(ib_aempty), 128'(sb.size() <= 1));
        chk("frame_cnt", 128'(frame_cnt), 128'(frames_model));
        chk("underflow_err", 128'(underflow_err), 128'(uf_model));
        tvalid = v;
        {tlast, tid, tuser, tstrb, tdata} = beat;
        ib_rd = rd;
        if (rd && sb.size() == 0) uf_model = 1'b1;
        if (rd && !ib_empty) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 128'(1), 128'(0));
            end else begin
                exp_head = sb.pop_front();
                chk("pop_data", 128'(ib_data), 128'(exp_head));
                if (exp_head[EW-1]) frames_model = frames_model + 16'd1;
            end
        end
        if (v && tready) begin
            sb.push_back(beat);
            accepted++;
        end
        rdy_model = sb.size() < 16;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{64'h0123456789ABCDEF, 8'hFF, 8'h01, 1'b0, 1'b1,
                    {1'b1, 1'b0, 8'h01, 8'hFF, 64'h0123456789ABCDEF}, 1};
        vecs[1] = '{64'hDEADBEEFCAFEF00D, 8'h0F, 8'hA5, 1'b1, 1'b0,
                    {1'b0, 1'b1, 8'hA5, 8'h0F, 64'hDEADBEEFCAFEF00D}, 0};
        vecs[2] = '{64'h0000000000000000, 8'h00, 8'hFF, 1'b1, 1'b1,
                    {1'b1, 1'b1, 8'hFF, 8'h00, 64'h0000000000000000}, 1};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 8'h80, 8'h00, 1'b0, 1'b0,
                    {1'b0, 1'b0, 8'h00, 8'h80, 64'hFFFFFFFFFFFFFFFF}, 0};

        // Reset, then release: tready rises one edge later
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 128'(tready), 128'(0));
        chk("rst_empty", 128'(ib_empty), 128'(1));
        chk("rst_aempty", 128'(ib_aempty), 128'(1));
        chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("tready_after_release", 128'(tready), 128'(1));
        step(1'b0, '0, 1'b0);

        // Table vectors: single beat push, head check, pop
        for (int i = 0; i < 4; i++) begin
            step(1'b1, {vecs[i].last, vecs[i].id, vecs[i].user, vecs[i].strb, vecs[i].data}, 1'b0);
            chk("vec_empty", 128'(ib_empty), 128'(0));
            chk("vec_head", 128'(ib_data), 128'(vecs[i].exp_head));
            fbase = frame_cnt;
            step(1'b0, '0, 1'b1);
            chk("vec_empty_after_pop", 128'(ib_empty), 128'(1));
            chk("vec_frame_inc", 128'(frame_cnt - fbase), 128'(vecs[i].exp_finc));
        end

        // Fill to full, hold tvalid, then a single pop reopens tready
        accepted = 0;
        for (int i = 0; i < 20; i++) step(1'b1, mk_beat(64'h100 + 64'(i), 1'b0), 1'b0);
        chk("fill_accepted", 128'(accepted), 128'(16));
        chk("full_tready", 128'(tready), 128'(0));
        step(1'b1, mk_beat(64'h200, 1'b1), 1'b1);
        chk("tready_after_pop", 128'(tready), 128'(1));
        step(1'b1, mk_beat(64'h200, 1'b1), 1'b0);
        chk("accepted_17th", 128'(accepted), 128'(17));
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        chk("drained", 128'(sb.size()), 128'(0));

        // Streaming push+pop for 1000 beats, tlast every 8th
        fbase = frame_cnt;
        stalls = 0;
        accepted = 0;
        step(1'b1, mk_beat({$urandom, $urandom}, 1'b0), 1'b0);
        for (int i = 1; i < 1000; i++) begin
            if (!tready) stalls++;
            step(1'b1, mk_beat({$urandom, $urandom}, (i % 8) == 7), 1'b1);
        end
        step(1'b0, '0, 1'b1);
        chk("stream_stalls", 128'(stalls), 128'(0));
        chk("stream_accepted", 128'(accepted), 128'(1000));
        chk("stream_frames", 128'(16'(frame_cnt - fbase)), 128'(125));

        // Read while empty: sticky error, no pointer movement
        step(1'b0, '0, 1'b1);
        chk("underflow_set", 128'(underflow_err), 128'(1));
        step(1'b1, mk_beat(64'hA5A5_0000_1111_2222, 1'b1), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("underflow_sticky", 128'(underflow_err), 128'(1));

        // Fill to 10 then async reset mid-cycle
        for (int i = 0; i < 10; i++) step(1'b1, mk_beat(64'hBAD0 + 64'(i), 1'b1), 1'b0);
        tvalid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_tready", 128'(tready), 128'(0));
        chk("async_empty", 128'(ib_empty), 128'(1));
        chk("async_aempty", 128'(ib_aempty), 128'(1));
        chk("async_frame_cnt", 128'(frame_cnt), 128'(0));
        chk("async_underflow", 128'(underflow_err), 128'(0));
        sb.delete();
        rdy_model = 1'b0;
        uf_model = 1'b0;
        frames_model = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, mk_beat(64'hF00D_F00D_F00D_F00D, 1'b1), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("post_reset_frames", 128'(frame_cnt), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cr_huf_comp_sa_axi4s_ib.md
Name: cr_huf_comp_sa_axi4s_ib

Overview:
- AXI4-stream slave input buffer for the huffman-compressor standalone TLV path; sits directly upstream of the TLV parser stage.
- Accepts raw beats from the upstream AXI4-stream master and stores them in a first-word-fall-through FIFO.
- Presents them on the empty/aempty/rd pull interface the parser consumes.
- Also counts delivered frames and flags reads of an empty FIFO.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4.
- AEMPTY_VAL, 1, ob_aempty asserted when occupancy ≤ AEMPTY_VAL.
- DW, 64, tdata width; tstrb width is DW/8.
- UW, 8, tuser width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- axi4s_ib_tvalid  in  1  upstream beat valid
- axi4s_ib_tready  out  1  registered ready to upstream
- axi4s_ib_tdata  in  DW  beat data
- axi4s_ib_tstrb  in  DW/8  byte strobes
- axi4s_ib_tuser  in  UW  sideband (SOT/EOT flags etc., passed opaque)
- axi4s_ib_tid  in  1  stream id
- axi4s_ib_tlast  in  1  end of frame
- ib_empty  out  1  FIFO empty
- ib_aempty  out  1  occupancy ≤ AEMPTY_VAL
- ib_rd  in  1  pop head entry
- ib_data  out  DW+DW/8+UW+2  head entry {tlast,tid,tuser,tstrb,tdata}; valid when ib_empty=0
- frame_cnt  out  16  frames popped (tlast beats read)
- underflow_err  out  1  sticky: ib_rd seen while ib_empty

Behaviour:
- Reset (rst_n low, async): occupancy=0, pointers=0, ib_empty=1, ib_aempty=1, axi4s_ib_tready=0, frame_cnt=0, underflow_err=0.
- Storage and contents are don't-care after reset.
- Push = axi4s_ib_tvalid & axi4s_ib_tready. Store the full beat at the write pointer.
- Pop = ib_rd & ~ib_empty. Advance the read pointer.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. occ = wptr - rptr.
- occ_next = occ + push - pop. Simultaneous push and pop leaves occ unchanged.
- Push and pop are legal at any occupancy, including push at occ=DEPTH-1 with pop at the same time.
- axi4s_ib_tready is a registered output: next value = (occ_next < DEPTH).
  - This gives full throughput (one beat per cycle) and can never overflow.
  - tready rises on the first clock edge after reset release.
  - tready drops the cycle after occ reaches DEPTH.
  - tready re-rises the cycle after a pop from full.
- Upstream must hold tvalid and the beat stable until accepted. The block does not check this.
- ib_empty and ib_aempty are registered from occ_next: ib_empty = (occ_next==0), ib_aempty = (occ_next ≤ AEMPTY_VAL).
- Latency: a beat accepted in cycle t appears on ib_data with ib_empty=0 in cycle t+1 (FWFT, fed by the read pointer).
- ib_data is the registered head or combinational storage read at rptr. It must be stable while ib_empty=0 and no pop occurs.
- ib_rd while ib_empty=1:
  - no pointer change;
  - underflow_err set next cycle;
  - underflow_err stays set until reset.
- frame_cnt: +1 on every pop whose head tlast=1; wraps 0xFFFF→0x0000.
- Reset mid-frame: all buffered beats are discarded; no partial-frame recovery.

Test Plan:
- Reset, then tvalid held low → tready=1 one cycle after rst_n rises; ib_empty=1, ib_aempty=1, frame_cnt=0.
- Push one beat (tdata=0x0123456789ABCDEF, tlast=1) with ib_rd low → next cycle ib_empty=0, ib_data matches. Then ib_rd=1 for 1 cycle → ib_empty=1 next cycle, frame_cnt=1.
- Push 16 beats back-to-back with no reads → tready deasserts the cycle after the 16th accept, exactly 16 accepted, ib_aempty=0 from occ=2. One pop → tready=1 next cycle, a 17th beat accepted.
- Continuous push and pop each cycle for 1000 beats, random tdata, tlast every 8th beat → no stall after fill, in-order data, occupancy constant at 1, frame_cnt=125.
- ib_rd pulsed with ib_empty=1 → pointers unchanged, underflow_err=1 next cycle and stays set through subsequent traffic.
- Fill to 10 entries, assert rst_n low asynchronously mid-cycle → outputs immediately at reset values; after release, no stale beats are delivered.
